// File: rtl/univ_shift_reg_n_if.sv
// Purpose: bundles the data, control and status signals of the universal
// shift register so a controller and the register share one connection.
// Signals:
//   en          single-step enable (ignored while a burst runs)
//   mode        operating mode 0..7
//   sin_l/sin_r serial inputs entering at MSB (shr) / LSB (shl)
//   pload       parallel load data
//   burst_start request a multi-cycle burst of the current mode
//   burst_len   number of burst steps, sampled with burst_start
//   q           register contents
//   sout_l/r    q[WIDTH-1] / q[0]
//   busy        burst in progress
//   done/err    one-cycle completion / rejection pulses
// Modports: master drives control and data, slave is the register itself.
interface univ_shift_reg_n_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = $clog2(WIDTH) + 1
);
  logic             en;
  logic [2:0]       mode;
  logic             sin_l;
  logic             sin_r;
  logic [WIDTH-1:0] pload;
  logic             burst_start;
  logic [LEN_W-1:0] burst_len;
  logic [WIDTH-1:0] q;
  logic             sout_l;
  logic             sout_r;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output en, mode, sin_l, sin_r, pload, burst_start, burst_len,
    input  q, sout_l, sout_r, busy, done, err
  );

  modport slave (
    input  en, mode, sin_l, sin_r, pload, burst_start, burst_len,
    output q, sout_l, sout_r, busy, done, err
  );
endinterface

// File: rtl/univ_shift_reg_n.sv
// Purpose: WIDTH-bit universal shift register with eight modes (hold, shl,
// shr, rol, ror, load, complement, asr) plus a burst engine that repeats a
// shift/rotate mode for a programmed number of cycles.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  univ_shift_reg_n_if slave modport (control in, q/status out)
module univ_shift_reg_n #(
  parameter int               WIDTH     = 8,
  parameter int               LEN_W     = $clog2(WIDTH) + 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input logic                clk,
  input logic                rst,
  univ_shift_reg_n_if.slave  bus
);

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_SHL  = 3'd1;
  localparam logic [2:0] MODE_SHR  = 3'd2;
  localparam logic [2:0] MODE_ROL  = 3'd3;
  localparam logic [2:0] MODE_ROR  = 3'd4;
  localparam logic [2:0] MODE_LOAD = 3'd5;
  localparam logic [2:0] MODE_CPL  = 3'd6;
  localparam logic [2:0] MODE_ASR  = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_q,     state_d;
  logic [WIDTH-1:0] shiftReg_q,  shiftReg_d;
  logic [LEN_W-1:0] count_q,     count_d;
  logic [2:0]       burstMode_q, burstMode_d;
  logic             done_q,      done_d;
  logic             err_q,       err_d;

  // One application of a mode to the register value; serial bits are live.
  function automatic logic [WIDTH-1:0] applyMode(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] v,
    input logic             sl,
    input logic             sr,
    input logic [WIDTH-1:0] p
  );
    logic [WIDTH-1:0] r;
    case (m)
      MODE_SHL:  r = {v[WIDTH-2:0], sr};
      MODE_SHR:  r = {sl, v[WIDTH-1:1]};
      MODE_ROL:  r = {v[WIDTH-2:0], v[WIDTH-1]};
      MODE_ROR:  r = {v[0], v[WIDTH-1:1]};
      MODE_LOAD: r = p;
      MODE_CPL:  r = ~v;
      MODE_ASR:  r = {v[WIDTH-1], v[WIDTH-1:1]};
      default:   r = v;
    endcase
    return r;
  endfunction

  // Only the shift and rotate modes make sense when repeated.
  function automatic logic isBurstable(input logic [2:0] m);
    return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) ||
           (m == MODE_ROR) || (m == MODE_ASR);
  endfunction

  // Next-state logic: burst request beats single step in IDLE; in BUSY the
  // latched mode runs once per edge and live control inputs are ignored.
  always_comb begin
    state_d     = state_q;
    shiftReg_d  = shiftReg_q;
    count_d     = count_q;
    burstMode_d = burstMode_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.burst_start) begin
          burstMode_d = bus.mode;
          if (!isBurstable(bus.mode)) begin
            err_d = 1'b1;
          end else if (bus.burst_len == '0) begin
            done_d = 1'b1;
          end else begin
            count_d = bus.burst_len;
            state_d = BUSY;
          end
        end else if (bus.en) begin
          shiftReg_d = applyMode(bus.mode, shiftReg_q, bus.sin_l, bus.sin_r, bus.pload);
        end
      end
      BUSY: begin
        shiftReg_d = applyMode(burstMode_q, shiftReg_q, bus.sin_l, bus.sin_r, bus.pload);
        count_d    = count_q - LEN_W'(1);
        // The edge consuming the last remaining step ends the burst.
        if (count_q == LEN_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any burst without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shiftReg_q  <= RESET_VAL;
      count_q     <= '0;
      burstMode_q <= MODE_HOLD;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shiftReg_q  <= shiftReg_d;
      count_q     <= count_d;
      burstMode_q <= burstMode_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.q      = shiftReg_q;
  assign bus.sout_l = shiftReg_q[WIDTH-1];
  assign bus.sout_r = shiftReg_q[0];
  assign bus.busy   = (state_q == BUSY);
  assign bus.done   = done_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_univ_shift_reg_n.sv
// Purpose: self-checking bench for univ_shift_reg_n (WIDTH=8). A reference
// model built from integer arithmetic and a queue of pending burst steps
// predicts every output after each clock edge.
module tb_univ_shift_reg_n;

  localparam int W = 8;
  localparam int L = 4;

  logic clk;
  logic rst;

  univ_shift_reg_n_if #(.WIDTH(W), .LEN_W(L)) bus ();

  univ_shift_reg_n #(.WIDTH(W), .LEN_W(L), .RESET_VAL(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int         total = 0;
  int         bad   = 0;
  int         mq    = 0;
  logic [2:0] pend[$];
  bit         expDone = 0;
  bit         expErr  = 0;

  // Reference behaviour of one mode application on an integer value.
  function automatic int modelOp(input int m, input int v, input int sl,
                                 input int sr, input int p);
    case (m)
      1: return (v * 2 + sr) % 256;
      2: return v / 2 + sl * 128;
      3: return (v * 2) % 256 + v / 128;
      4: return v / 2 + (v % 2) * 128;
      5: return p;
      6: return 255 - v;
      7: return v / 2 + (v / 128) * 128;
      default: return v;
    endcase
  endfunction

  // Single comparison point.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    checkOutput("q",      32'(bus.q),      32'(mq));
    checkOutput("sout_l", 32'(bus.sout_l), 32'(mq / 128));
    checkOutput("sout_r", 32'(bus.sout_r), 32'(mq % 2));
    checkOutput("busy",   32'(bus.busy),   32'(pend.size() > 0));
    checkOutput("done",   32'(bus.done),   32'(expDone));
    checkOutput("err",    32'(bus.err),    32'(expErr));
  endtask

  // Predict the effect of the current inputs, clock once, then compare.
  task automatic applyStimulus();
    int         nq;
    bit         nd;
    bit         ne;
    logic [2:0] op;
    nq = mq;
    nd = 0;
    ne = 0;
    if (pend.size() > 0) begin
      op = pend.pop_front();
      nq = modelOp(int'(op), mq, int'(bus.sin_l), int'(bus.sin_r), int'(bus.pload));
      if (pend.size() == 0) nd = 1;
    end else if (bus.burst_start) begin
      if (!(bus.mode inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd7})) ne = 1;
      else if (bus.burst_len == 0) nd = 1;
      else for (int i = 0; i < int'(bus.burst_len); i++) pend.push_back(bus.mode);
    end else if (bus.en) begin
      nq = modelOp(int'(bus.mode), mq, int'(bus.sin_l), int'(bus.sin_r), int'(bus.pload));
    end
    @(posedge clk);
    #1;
    mq      = nq;
    expDone = nd;
    expErr  = ne;
    checkAll();
  endtask

  // Asynchronous reset between edges; q must clear without waiting.
  task automatic pulseReset();
    rst = 1'b1;
    #1;
    mq = 0;
    pend.delete();
    expDone = 0;
    expErr  = 0;
    checkAll();
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic idleInputs();
    bus.en          = 1'b0;
    bus.mode        = 3'd0;
    bus.sin_l       = 1'b0;
    bus.sin_r       = 1'b0;
    bus.pload       = '0;
    bus.burst_start = 1'b0;
    bus.burst_len   = '0;
  endtask

  initial begin
    rst = 1'b1;
    idleInputs();
    bus.en    = 1'b1;
    bus.mode  = 3'd5;
    bus.pload = 8'hA5;

    // Reset holds q at zero even across an edge with load requested.
    #3;
    checkOutput("rst_q", 32'(bus.q), 32'h00);
    @(posedge clk);
    #1;
    checkAll();
    rst = 1'b0;
    #1;

    // Parallel load then single steps.
    applyStimulus();
    checkOutput("load_a5", 32'(bus.q), 32'hA5);
    bus.mode = 3'd1; bus.sin_r = 1'b1;
    applyStimulus();
    checkOutput("shl", 32'(bus.q), 32'h4B);
    bus.mode = 3'd5;
    applyStimulus();
    bus.mode = 3'd2; bus.sin_l = 1'b0;
    applyStimulus();
    checkOutput("shr", 32'(bus.q), 32'h52);
    bus.mode = 3'd5;
    applyStimulus();
    bus.mode = 3'd7;
    applyStimulus();
    checkOutput("asr", 32'(bus.q), 32'hD2);
    bus.en = 1'b0; bus.mode = 3'd6;
    applyStimulus();
    checkOutput("en_off", 32'(bus.q), 32'hD2);
    bus.en = 1'b1; bus.mode = 3'd5;
    applyStimulus();

    // Rotate-left burst of 3, with a second request ignored mid-burst.
    bus.en = 1'b0; bus.mode = 3'd3; bus.burst_len = 4'd3; bus.burst_start = 1'b1;
    applyStimulus();
    checkOutput("burst_hold", 32'(bus.q), 32'hA5);
    bus.burst_start = 1'b0;
    applyStimulus();
    bus.burst_start = 1'b1; bus.mode = 3'd5; bus.burst_len = 4'd9;
    applyStimulus();
    bus.burst_start = 1'b0;
    applyStimulus();
    checkOutput("burst_end", 32'(bus.q), 32'h2D);
    checkOutput("burst_done", 32'(bus.done), 32'h1);
    applyStimulus();

    // Rejected mode and zero-length burst.
    bus.burst_start = 1'b1; bus.mode = 3'd5; bus.burst_len = 4'd2;
    applyStimulus();
    checkOutput("burst_err", 32'(bus.err), 32'h1);
    bus.mode = 3'd1; bus.burst_len = 4'd0;
    applyStimulus();
    checkOutput("len0_done", 32'(bus.done), 32'h1);
    bus.burst_start = 1'b0;
    applyStimulus();

    // Reset after the second step of a ror burst aborts it.
    bus.burst_start = 1'b1; bus.mode = 3'd4; bus.burst_len = 4'd6;
    applyStimulus();
    bus.burst_start = 1'b0;
    applyStimulus();
    applyStimulus();
    pulseReset();
    applyStimulus();
    bus.en = 1'b1; bus.mode = 3'd5; bus.pload = 8'h2D;
    applyStimulus();
    checkOutput("reload", 32'(bus.q), 32'h2D);

    // Complement, then an 8-step serialiser burst.
    bus.mode = 3'd6;
    applyStimulus();
    checkOutput("cpl", 32'(bus.q), 32'hD2);
    bus.en = 1'b0; bus.mode = 3'd2; bus.burst_len = 4'd8; bus.burst_start = 1'b1;
    applyStimulus();
    bus.burst_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.sin_l = (i % 2 == 0);
      applyStimulus();
    end
    checkOutput("serial", 32'(bus.q), 32'h55);

    // Randomised traffic with occasional asynchronous resets.
    for (int c = 0; c < 600; c++) begin
      bus.en          = 1'($urandom % 2);
      bus.mode        = 3'($urandom % 8);
      bus.sin_l       = 1'($urandom % 2);
      bus.sin_r       = 1'($urandom % 2);
      bus.pload       = 8'($urandom % 256);
      bus.burst_start = ($urandom % 6 == 0);
      bus.burst_len   = 4'($urandom % 16);
      if ($urandom % 97 == 0) pulseReset();
      applyStimulus();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg_n.md
Name: univ_shift_reg_n

Overview:
Parametrised universal shift register: WIDTH-bit storage with eight operating modes: hold, logical shifts, rotates, parallel load, complement and arithmetic right shift.
Adds a burst engine that applies a shift/rotate mode for a programmed number of consecutive cycles, with a busy/done/err handshake.
Used as the general-purpose shifter/serialiser element in the lab datapath library.

Parameters:
WIDTH, 8, register width in bits (>=2)
LEN_W, $clog2(WIDTH)+1, width of burst_len
RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
en  input  1  single-step enable, used only when not busy
mode  input  3  0 hold, 1 shl, 2 shr, 3 rol, 4 ror, 5 load, 6 complement, 7 asr
sin_l  input  1  serial in entering at MSB on shr
sin_r  input  1  serial in entering at LSB on shl
pload  input  WIDTH  parallel load data (mode 5)
burst_start  input  1  request a multi-cycle burst of the current mode
burst_len  input  LEN_W  number of burst steps, sampled with burst_start
q  output  WIDTH  register contents
sout_l  output  1  q[WIDTH-1], combinational
sout_r  output  1  q[0], combinational
busy  output  1  high while a burst is in progress
done  output  1  one-cycle pulse: burst completed
err  output  1  one-cycle pulse: burst request rejected

Behaviour:
- Reset (async, rst=1): q=RESET_VAL, busy=0, done=0, err=0, step counter=0, state IDLE. Takes effect immediately and overrides everything.
- Reset mid-burst: the burst is aborted. No done pulse is produced, and the next operation starts from IDLE.
- Mode functions, all updating q at a rising edge:
  - shl: {q[W-2:0], sin_r}
  - shr: {sin_l, q[W-1:1]}
  - rol: {q[W-2:0], q[W-1]}
  - ror: {q[0], q[W-1:1]}
  - load: pload
  - complement: ~q
  - asr: {q[W-1], q[W-1:1]}
  - hold: q
- States: IDLE and BUSY.
- IDLE, priority per edge:
  1. burst_start=1: evaluated regardless of en; mode and burst_len are latched; q holds this edge.
     - Mode not in {1,2,3,4,7}: err=1 for one cycle, stay IDLE.
     - burst_len=0: done=1 for one cycle, busy stays 0, stay IDLE.
     - Otherwise: counter=burst_len, busy=1, go to BUSY.
  2. Else en=1: apply mode once; 1-cycle latency, q reflects the result after the edge.
  3. Else: hold.
- BUSY:
  - Each edge applies the latched mode once and decrements counter.
  - Live inputs en, mode and burst_start are ignored; burst_start is not queued.
  - sin_l and sin_r are sampled live on every step, which makes serialiser use possible.
  - On the edge performing step burst_len: busy=0 and done=1 for exactly one cycle, return to IDLE.
  - busy is therefore high for exactly burst_len cycles.
- Burst length: any value up to 2^LEN_W-1 is legal. Rotates wrap modulo WIDTH naturally; shifts beyond WIDTH fill entirely with serial or sign bits.
- Outputs: done and err are registered and never high together. sout_l and sout_r follow q with no extra latency.

Test Plan (WIDTH=8, RESET_VAL=0x00):
1. rst pulse, then en=1, mode=5, pload=0xA5 -> q=0x00 during reset; q=0xA5 after one edge; sout_l=1, sout_r=1.
2. From 0xA5, single steps:
   - mode=1, sin_r=1 -> 0x4B
   - reload 0xA5; mode=2, sin_l=0 -> 0x52
   - reload 0xA5; mode=7 -> 0xD2
   - en=0 with any mode -> q unchanged
3. From 0xA5, burst_start with mode=3, burst_len=3 -> q holds on the start edge, then 0x4B, 0x96, 0x2D. busy is high for 3 cycles; done pulses once on the final edge; final q=0x2D.
4. Burst error and edge cases:
   - burst_start with mode=5 -> err pulses 1 cycle, busy=0, q unchanged.
   - burst_start with mode=1, burst_len=0 -> done pulses 1 cycle, busy never rises, q unchanged.
   - burst_start again while busy -> ignored.
5. Burst mode=4, burst_len=6 from 0x2D; assert rst after the 2nd step -> q=0x00 immediately (before the next edge), busy=0, no done pulse. A new load works on the next edge after rst is released.
6. mode=6 on 0x2D with en=1 -> 0xD2. Then burst mode=2, burst_len=8 with sin_l toggling 1,0,1,0,... -> q ends equal to the serial stream (first bit at LSB) = 0x55.
